// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// State encoding is fixed so that debug traces read the same across tools.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;
  localparam logic [31:0] NOP_INST          = 32'h0000_0000;

  // One queued fetch: the instruction word and the address it came from.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  localparam entry_t NOP_ENTRY = '{inst: NOP_INST, pc: 32'h0000_0000};

endpackage

// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer, instruction memory, control and decode.
// slave is the sequencer side; master is the environment (memory, execute, decode).
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic        start;
  logic        halt_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] inst;
  // Decode handshake: an instruction transfers on a cycle where out_valid and
  // out_ready are both high; out_valid never depends on out_ready, and the
  // head (out_inst/out_pc) is stable while out_valid is high and not taken,
  // except that a redirect discards it.
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        busy;
  state_t      dbg_state;

  modport slave (
    input  start, halt_req, redirect_valid, redirect_pc, inst, out_ready,
    output pc, out_valid, out_inst, out_pc, busy, dbg_state
  );

  modport master (
    output start, halt_req, redirect_valid, redirect_pc, inst, out_ready,
    input  pc, out_valid, out_inst, out_pc, busy, dbg_state
  );

endinterface

// File: rtl/fetch_sequencer_queue.sv
// Small FIFO of fetched {inst, pc} entries with flush. DEPTH must be 2 or 4 so
// the pointers wrap naturally at their bit width.
module fetch_queue
  import fetch_sequencer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        push_data,
  output entry_t        head_data,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= NOP_ENTRY;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // An empty queue presents the NOP entry rather than stale storage.
  assign head_data = (count != '0) ? mem[rd_ptr] : NOP_ENTRY;

endmodule

// File: rtl/fetch_sequencer.sv
// Drives the instruction memory address, buffers fetched words toward decode,
// and handles start/halt control plus execute-stage redirects.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = DEFAULT_BOOT_ADDR,
  parameter logic [31:0] PC_INC    = 32'd1,
  parameter int          DEPTH     = 2
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.slave   bus
);

  localparam int CW = $clog2(DEPTH + 1);

  state_t          state;
  state_t          state_next;
  logic [31:0]     pc_q;
  logic [CW-1:0]   count;
  entry_t          head;
  logic            push;
  logic            pop;
  logic            flush;
  logic            busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Redirect never changes state on its own; combined with start/halt the
  // ordinary transitions below give the required outcome.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (bus.start)    state_next = S_FETCH;
      S_FETCH:  if (bus.halt_req) state_next = S_HALTED;
      S_HALTED: if (bus.start)    state_next = S_FETCH;
      default:                    state_next = S_IDLE;
    endcase
  end

  // The fetch decision uses the pre-pop count, so a full queue never fetches.
  always_comb begin
    flush = bus.redirect_valid;
    pop   = (count != '0) && bus.out_ready && !bus.redirect_valid;
    push  = (state == S_FETCH) && (count < CW'(DEPTH))
            && !bus.redirect_valid && !bus.halt_req;
    busy  = (state == S_FETCH) || (count != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= BOOT_ADDR;
    end else if (bus.redirect_valid) begin
      pc_q <= bus.redirect_pc;
    end else if (push) begin
      pc_q <= pc_q + PC_INC;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data ('{inst: bus.inst, pc: pc_q}),
    .head_data (head),
    .count     (count)
  );

  assign bus.pc        = pc_q;
  assign bus.out_valid = (count != '0);
  assign bus.out_inst  = head.inst;
  assign bus.out_pc    = head.pc;
  assign bus.busy      = busy;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then random traffic, checked
// against a queue-based reference model and a delivery scoreboard.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'h0000_0000;

  logic clk;
  logic reset;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .BOOT_ADDR (BOOT),
    .PC_INC    (32'd1),
    .DEPTH     (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Instruction memory model: combinational from pc.
  assign bus.inst = 32'hA000_0000 | bus.pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: the queue contents in delivery order plus control state.
  logic [63:0] exp_q[$];
  int          m_state;   // 0 idle, 1 fetching, 2 halted
  logic [31:0] m_pc;
  int          m_count;
  bit          armed = 0;
  bit          after_reset = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit pop_now;
    bit push_now;
    if (reset) begin
      m_state = 0;
      m_pc = BOOT;
      m_count = 0;
      exp_q.delete();
      armed = 1;
      after_reset = 1;
    end else if (armed) begin
      pop_now  = (m_count != 0) && bus.out_ready && !bus.redirect_valid;
      push_now = (m_state == 1) && (m_count < DEPTH) && !bus.redirect_valid && !bus.halt_req;
      if (bus.redirect_valid) begin
        m_pc = bus.redirect_pc;
        m_count = 0;
        exp_q.delete();
        after_reset = 0;
      end else begin
        if (push_now) begin
          exp_q.push_back({32'hA000_0000 | m_pc, m_pc});
          m_pc = m_pc + 32'd1;
          after_reset = 0;
        end
        m_count = m_count + int'(push_now) - int'(pop_now);
      end
      if (bus.start && m_state != 1) m_state = 1;
      else if (bus.halt_req && m_state == 1) m_state = 2;
    end
  end

  // Monitor: compares outputs to the model and retires deliveries in order.
  always @(negedge clk) begin
    logic [63:0] e;
    if (armed) begin
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_count != 0});
      check("pc", bus.pc, m_pc);
      check("busy", {31'd0, bus.busy}, {31'd0, (m_state == 1) || (m_count != 0)});
      check("state", {30'd0, bus.dbg_state}, m_state);
      if (after_reset) begin
        check("reset_out_inst", bus.out_inst, NOP_INST);
        check("reset_out_pc", bus.out_pc, 32'h0);
      end
      if (bus.out_valid && bus.out_ready && !bus.redirect_valid && !reset) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL delivery actual=%h expected=<none queued>", bus.out_pc);
        end else begin
          e = exp_q.pop_front();
          check("out_inst", bus.out_inst, e[63:32]);
          check("out_pc", bus.out_pc, e[31:0]);
        end
      end
    end
  end

  task automatic step(input logic s, input logic h, input logic rv,
                      input logic [31:0] rp, input logic rdy, input logic rst);
    bus.start = s;
    bus.halt_req = h;
    bus.redirect_valid = rv;
    bus.redirect_pc = rp;
    bus.out_ready = rdy;
    reset = rst;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, rdy, 0);
  endtask

  initial begin
    step(0, 0, 0, 32'h0, 0, 1);
    step(0, 0, 0, 32'h0, 0, 1);
    // Start and stream one per cycle.
    step(1, 0, 0, 32'h0, 1, 0);
    idle(5, 1);
    // Back-pressure fills the queue, then release.
    idle(4, 0);
    idle(2, 1);
    idle(2, 0);
    // Redirect while full.
    step(0, 0, 1, 32'h0000_0040, 0, 0);
    idle(4, 1);
    idle(2, 0);
    // Halt with entries queued, drain, resume.
    step(0, 1, 0, 32'h0, 0, 0);
    idle(2, 0);
    idle(4, 1);
    step(1, 0, 0, 32'h0, 1, 0);
    idle(3, 1);
    idle(3, 0);
    // Reset mid-fetch with a full queue; nothing fetches until start.
    step(0, 0, 0, 32'h0, 0, 1);
    idle(3, 1);
    // Wrap boundary.
    step(0, 0, 1, 32'hFFFF_FFFF, 1, 0);
    step(1, 0, 0, 32'h0, 1, 0);
    idle(4, 1);
    // Redirect together with halt.
    step(0, 1, 1, 32'h0000_0123, 1, 0);
    idle(2, 1);
    step(1, 0, 0, 32'h0, 1, 0);
    idle(3, 1);
    // Redirect together with start from idle.
    step(0, 0, 0, 32'h0, 0, 1);
    step(1, 0, 1, 32'h0000_0777, 1, 0);
    idle(4, 1);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE + 32'($urandom_range(0, 1))
                                         : $urandom();
      step($urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 6,
           $urandom_range(0, 99) < 8,
           rp,
           $urandom_range(0, 99) < 65,
           $urandom_range(0, 199) == 0);
    end

    step(0, 1, 0, 32'h0, 1, 0);
    idle(6, 1);
    check("final_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
